// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter owner and instruction-flow sequencer.
// Handles jumps/branches, STOP halt and IN/OUT stall handshakes.
module pc_sequencer #(
  parameter int ADDR_W   = 10,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jump,
  input  logic              branch,
  input  logic              cond,
  input  logic              cond_flag,
  input  logic              sleep,
  input  logic              inop,
  input  logic              outop,
  input  logic [ADDR_W-1:0] jaddr,
  input  logic [ADDR_W-1:0] boff,
  input  logic              in_valid,
  input  logic              out_ready,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              commit,
  output logic              in_ack,
  output logic              out_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {
    RUN,
    WAIT_IN,
    WAIT_OUT,
    HALT
  } state_t;

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic              take;
  logic              commit_c, in_ack_c, out_valid_c;
  logic              d_sleep, d_in, d_out, d_jmp, d_br;

  assign pc_inc    = pc + ONE;
  assign link_addr = pc_inc;
  assign take      = ~cond | cond_flag;
  assign halted    = (state == HALT);

  // Priority resolved here so the decoder below sees one-hot selects
  assign d_sleep = sleep;
  assign d_in    = inop & ~sleep;
  assign d_out   = outop & ~inop & ~sleep;
  assign d_jmp   = jump & ~outop & ~inop & ~sleep;
  assign d_br    = branch & ~jump & ~outop & ~inop & ~sleep;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    commit_c    = 1'b0;
    in_ack_c    = 1'b0;
    out_valid_c = 1'b0;
    unique case (state)
      RUN: begin
        unique case (1'b1)
          d_sleep: begin
            commit_c  = 1'b1;
            state_nxt = HALT;
          end
          d_in: begin
            if (in_valid) begin
              commit_c = 1'b1;
              in_ack_c = 1'b1;
              pc_nxt   = pc_inc;
            end else begin
              state_nxt = WAIT_IN;
            end
          end
          d_out: begin
            out_valid_c = 1'b1;
            if (out_ready) begin
              commit_c = 1'b1;
              pc_nxt   = pc_inc;
            end else begin
              state_nxt = WAIT_OUT;
            end
          end
          d_jmp: begin
            commit_c = 1'b1;
            pc_nxt   = take ? jaddr : pc_inc;
          end
          d_br: begin
            commit_c = 1'b1;
            pc_nxt   = take ? pc + boff : pc_inc;
          end
          default: begin
            commit_c = 1'b1;
            pc_nxt   = pc_inc;
          end
        endcase
      end
      WAIT_IN: begin
        commit_c = in_valid;
        in_ack_c = in_valid;
        if (in_valid) begin
          pc_nxt    = pc_inc;
          state_nxt = RUN;
        end
      end
      WAIT_OUT: begin
        out_valid_c = 1'b1;
        commit_c    = out_ready;
        if (out_ready) begin
          pc_nxt    = pc_inc;
          state_nxt = RUN;
        end
      end
      HALT: begin
        if (resume) begin
          pc_nxt    = pc_inc;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Handshakes and commits are suppressed while reset is held
  assign commit    = commit_c & ~reset;
  assign in_ack    = in_ack_c & ~reset;
  assign out_valid = out_valid_c & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      pc      <= RST_PC;
      retired <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (commit && retired != {CNT_W{1'b1}})
        retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed + random stimulus against a
// behavioural model of the sequencer.
module tb_pc_sequencer;

  localparam int AW = 10;
  localparam int AM = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          jump, branch, cond, cond_flag;
  logic          sleep, inop, outop;
  logic [AW-1:0] jaddr, boff;
  logic          in_valid, out_ready, resume;

  logic [AW-1:0] pc, link_addr;
  logic          commit, in_ack, out_valid, halted;
  logic [15:0]   retired;

  logic [AW-1:0] pc4, link4;
  logic          commit4, in_ack4, out_valid4, halted4;
  logic [3:0]    retired4;

  int checks = 0;
  int errors = 0;

  // model state: mode 0 run, 1 waiting for input, 2 waiting for sink, 3 halted
  int m_pc, m_mode, m_ret, m_ret4;
  int e_commit, e_ack, e_ov;
  int n_pc, n_mode;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .jump(jump), .branch(branch),
    .cond(cond), .cond_flag(cond_flag), .sleep(sleep),
    .inop(inop), .outop(outop), .jaddr(jaddr), .boff(boff),
    .in_valid(in_valid), .out_ready(out_ready), .resume(resume),
    .pc(pc), .link_addr(link_addr), .commit(commit),
    .in_ack(in_ack), .out_valid(out_valid), .halted(halted),
    .retired(retired)
  );

  pc_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .jump(jump), .branch(branch),
    .cond(cond), .cond_flag(cond_flag), .sleep(sleep),
    .inop(inop), .outop(outop), .jaddr(jaddr), .boff(boff),
    .in_valid(in_valid), .out_ready(out_ready), .resume(resume),
    .pc(pc4), .link_addr(link4), .commit(commit4),
    .in_ack(in_ack4), .out_valid(out_valid4), .halted(halted4),
    .retired(retired4)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    reset = 0; jump = 0; branch = 0; cond = 0; cond_flag = 0;
    sleep = 0; inop = 0; outop = 0; jaddr = '0; boff = '0;
    in_valid = 0; out_ready = 0; resume = 0;
  endtask

  task automatic model();
    int tk;
    e_commit = 0; e_ack = 0; e_ov = 0;
    n_pc = m_pc; n_mode = m_mode;
    tk = (!cond || cond_flag) ? 1 : 0;
    if (reset) begin
      n_pc = 0; n_mode = 0;
    end else if (m_mode == 0) begin
      if (sleep) begin
        e_commit = 1; n_mode = 3;
      end else if (inop) begin
        if (in_valid) begin
          e_commit = 1; e_ack = 1; n_pc = (m_pc + 1) % AM;
        end else n_mode = 1;
      end else if (outop) begin
        e_ov = 1;
        if (out_ready) begin
          e_commit = 1; n_pc = (m_pc + 1) % AM;
        end else n_mode = 2;
      end else begin
        e_commit = 1;
        if (jump && tk) n_pc = int'(jaddr);
        else if (!jump && branch && tk) n_pc = (m_pc + int'(boff)) % AM;
        else n_pc = (m_pc + 1) % AM;
      end
    end else if (m_mode == 1) begin
      e_commit = in_valid; e_ack = in_valid;
      if (in_valid) begin n_pc = (m_pc + 1) % AM; n_mode = 0; end
    end else if (m_mode == 2) begin
      e_ov = 1; e_commit = out_ready;
      if (out_ready) begin n_pc = (m_pc + 1) % AM; n_mode = 0; end
    end else begin
      if (resume) begin n_pc = (m_pc + 1) % AM; n_mode = 0; end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model();
    check("pc", 32'(pc), 32'(m_pc));
    check("link", 32'(link_addr), 32'((m_pc + 1) % AM));
    check("commit", 32'(commit), 32'(e_commit));
    check("in_ack", 32'(in_ack), 32'(e_ack));
    check("out_valid", 32'(out_valid), 32'(e_ov));
    check("halted", 32'(halted), 32'(m_mode == 3));
    check("retired", 32'(retired), 32'(m_ret));
    check("retired4", 32'(retired4), 32'(m_ret4));
    check("pc4", 32'(pc4), 32'(m_pc));
    @(posedge clk);
    if (reset) begin
      m_ret = 0; m_ret4 = 0;
    end else if (e_commit != 0) begin
      if (m_ret < 65535) m_ret++;
      if (m_ret4 < 15) m_ret4++;
    end
    m_pc = n_pc; m_mode = n_mode;
    #1;
  endtask

  initial begin
    clr();
    reset = 1;
    m_pc = 0; m_mode = 0; m_ret = 0; m_ret4 = 0;
    @(posedge clk); #1;
    cycle();
    reset = 0;
    repeat (5) cycle();
    check("ret_after5", 32'(retired), 32'd5);
    // branch back by 2 from pc 3
    jump = 1; jaddr = 10'd3; cycle(); clr();
    branch = 1; boff = 10'h3FE; cycle();
    check("br_taken", 32'(pc), 32'd1);
    jump = 1; jaddr = 10'd3; branch = 0; cycle(); clr();
    branch = 1; boff = 10'h3FE; cond = 1; cond_flag = 0; cycle(); clr();
    check("br_not_taken", 32'(pc), 32'd4);
    jump = 1; jaddr = 10'd1023; cycle(); clr();
    cycle();
    check("pc_wrap", 32'(pc), 32'd0);
    // IN stall
    inop = 1; cycle(); clr();
    inop = 1; cycle(); cycle(); in_valid = 1; cycle(); clr();
    // OUT stall, then OUT stall aborted by reset
    outop = 1; cycle(); clr();
    cycle(); out_ready = 1; cycle(); clr();
    outop = 1; cycle(); clr();
    reset = 1; cycle(); reset = 0;
    check("rst_pc", 32'(pc), 32'd0);
    cycle();
    // STOP at 7, then resume
    jump = 1; jaddr = 10'd7; cycle(); clr();
    sleep = 1; cycle(); clr();
    repeat (10) cycle();
    check("halt_pc", 32'(pc), 32'd7);
    resume = 1; cycle(); clr();
    check("resume_pc", 32'(pc), 32'd8);
    jump = 1; branch = 1; jaddr = 10'h55; boff = 10'd9; cycle(); clr();
    check("jmp_wins", 32'(pc), 32'h55);
    repeat (20) cycle();
    check("sat4", 32'(retired4), 32'd15);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      sleep     = ($urandom_range(0, 29) == 0);
      inop      = ($urandom_range(0, 7) == 0);
      outop     = ($urandom_range(0, 7) == 0);
      jump      = ($urandom_range(0, 5) == 0);
      branch    = ($urandom_range(0, 4) == 0);
      cond      = 1'($urandom);
      cond_flag = 1'($urandom);
      jaddr     = AW'($urandom);
      boff      = AW'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      resume    = ($urandom_range(0, 3) == 0);
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Consumer end of the control-unit interface: takes the decoded control flags (jump, branch, cond, sleep, inop, outop) each cycle and owns the program counter.
- Sequences instruction flow: PC update, conditional jumps/branches, halt on STOP, stall-and-handshake for IN/OUT.
- Supplies `commit`, which gates register-file and memory writes, so stalled or halted instructions have no architectural effect.

Parameters:
- ADDR_W, 10, PC / instruction-address width.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- jump  in  1  absolute jump request (jump/jal/jc)
- branch  in  1  PC-relative branch request (branch/bal/bc)
- cond  in  1  jump/branch is conditional on cond_flag
- cond_flag  in  1  registered compare result (bit 0 of last compare)
- sleep  in  1  STOP instruction
- inop  in  1  IN instruction
- outop  in  1  OUT instruction
- jaddr  in  ADDR_W  absolute jump target
- boff  in  ADDR_W  signed two's-complement branch offset
- in_valid  in  1  external input word available
- out_ready  in  1  external sink accepts output word
- resume  in  1  leave HALT
- pc  out  ADDR_W  current instruction address
- link_addr  out  ADDR_W  pc+1 mod 2^ADDR_W, for jal/bal
- commit  out  1  current instruction completes this cycle
- in_ack  out  1  input word consumed this cycle
- out_valid  out  1  output word presented
- halted  out  1  state == HALT
- retired  out  CNT_W  committed-instruction count, saturating

Behaviour:
- Reset (synchronous, highest priority, including mid-WAIT or HALT):
  - pc = RESET_PC, state = RUN, retired = 0.
  - No in_ack or out_valid asserted in the reset cycle.
- States: RUN, WAIT_IN, WAIT_OUT, HALT. Outputs are Mealy on the current-cycle inputs. PC and state are registered.
- RUN, decode priority sleep > inop > outop > jump > branch > sequential:
  - sleep: commit = 1, pc held, next state HALT.
  - inop, in_valid = 1: commit = 1, in_ack = 1, pc += 1, stay RUN.
  - inop, in_valid = 0: commit = 0, pc held, next state WAIT_IN.
  - outop: out_valid = 1. If out_ready = 1: commit = 1, pc += 1. Else: commit = 0, next state WAIT_OUT.
  - jump, taken when cond = 0 or cond_flag = 1: pc <= jaddr. Otherwise pc += 1. commit = 1.
  - branch, same take rule: pc <= pc + boff, truncated to ADDR_W (wraps). Otherwise pc += 1. commit = 1.
  - jump and branch both set: jump wins.
  - no flag: pc += 1, commit = 1.
- WAIT_IN:
  - Decode inputs are ignored; the instruction is already latched by pc hold.
  - commit = in_ack = in_valid.
  - On in_valid: pc += 1, next state RUN.
  - Otherwise hold, no timeout.
- WAIT_OUT:
  - out_valid = 1.
  - commit = out_ready.
  - On out_ready: pc += 1, next state RUN.
- HALT:
  - commit = 0, pc frozen, halted = 1.
  - resume = 1: pc += 1, next state RUN. The first commit occurs the following cycle.
- Arithmetic:
  - pc + 1 wraps from 2^ADDR_W−1 to 0.
  - link_addr = pc + 1 with the same wrap, valid in every state.
- retired:
  - Increments by 1 on every commit = 1 cycle.
  - Saturates at 2^CNT_W−1.
- One-cycle guarantees:
  - in_ack and commit never assert for the same IN instruction twice.
  - The out_valid && out_ready handshake completes exactly once per OUT.

Test Plan:
- Reset, then 5 cycles with no flags: pc 0,1,2,3,4; commit = 1 each cycle; retired = 5; link_addr = pc+1.
- pc = 3, branch = 1, boff = 10'h3FE (−2), cond = 0: next pc = 1. Repeat with cond = 1, cond_flag = 0: next pc = 4. pc = 1023, no flag: pc wraps to 0.
- inop with in_valid = 0 for 3 cycles, then 1: commit = 0 for 3 cycles; single-cycle in_ack = commit = 1 on the 4th; pc advances once; retired increments once.
- outop with out_ready = 0 for 2 cycles: out_valid = 1 held across all 3 cycles; commit only on the out_ready cycle. Also assert reset mid-WAIT_OUT: pc = RESET_PC, state RUN, out_valid = 0 the next cycle.
- sleep at pc = 7: halted = 1, pc stays 7 for 10 cycles, commit = 0; resume pulse gives pc = 8 next cycle. Also jump and branch both set with jaddr = 0x55: pc = 0x55.
- CNT_W = 4 build, 20 sequential instructions: retired saturates at 15.
